// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: a single-outstanding imem request engine feeding a
// 2-entry instruction FIFO, with execute-stage redirect and stale-response dropping.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        stall_f,
   input  logic        pcsrc_e,
   input  logic [31:0] pc_target_e,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        valid_f,
   output logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus4_f
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]       state, state_nx;
   logic [31:0]      fetch_pc, fetch_pc_nx, req_pc, redir_pc;
   logic             drop, drop_nx;
   logic [1:0][31:0] fifo_pc, fifo_instr;
   logic             rd_ptr, wr_ptr;
   logic [1:0]       count, count_nx;
   logic             granted, push, pop;

   assign redir_pc = pc_target_e & ~32'h3;
   assign granted  = (state == S_REQ) & imem_gnt;
   // redirect flushes the FIFO, so neither pop nor push matters in that cycle
   assign pop      = valid_f & ~stall_f & ~pcsrc_e;
   assign push     = (state == S_WAIT) & imem_rvalid & ~drop & ~pcsrc_e;

   always_comb begin
      count_nx    = pcsrc_e ? 2'd0 : (count + 2'(push) - 2'(pop));
      fetch_pc_nx = fetch_pc;
      if (pcsrc_e)      fetch_pc_nx = redir_pc;
      else if (granted) fetch_pc_nx = fetch_pc + 32'd4;
      state_nx = state;
      drop_nx  = drop;
      case (state)
         S_IDLE: if (count_nx < 2'd2) state_nx = S_REQ;
         S_REQ: begin
            if (imem_gnt) begin
               state_nx = S_WAIT;
               drop_nx  = pcsrc_e;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               drop_nx  = 1'b0;
               state_nx = (count_nx < 2'd2) ? S_REQ : S_IDLE;
            end else if (pcsrc_e) begin
               drop_nx = 1'b1;
            end
         end
         default: state_nx = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC & ~32'h3;
         req_pc   <= 32'h0;
         drop     <= 1'b0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         drop     <= drop_nx;
         count    <= count_nx;
         if (granted) req_pc <= fetch_pc;
         if (pcsrc_e) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
         end else begin
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push) wr_ptr <= ~wr_ptr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !srst) begin
         fifo_pc[wr_ptr]    <= req_pc;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

   // request gated by srst so nothing is issued while reset is held
   assign imem_req   = (state == S_REQ) & ~srst;
   assign imem_addr  = fetch_pc & ~32'h3;
   assign valid_f    = (count != 2'd0);
   assign pc_f       = valid_f ? fifo_pc[rd_ptr] : 32'h0;
   assign instr_f    = valid_f ? fifo_instr[rd_ptr] : NOP_INSTR;
   assign pc_plus4_f = pc_f + 32'd4;

endmodule
